// File: rtl/hack_mem_pkg.sv
// Hack data-side memory map: address/word types, region codes and map constants
// shared by the data memory responder and its storage blocks.
package hack_mem_pkg;

  typedef logic [14:0] addr_t;
  typedef logic [15:0] word_t;

  localparam addr_t RAM_BASE = 15'h0000;
  localparam addr_t RAM_TOP  = 15'h3FFF;
  localparam addr_t SCR_BASE = 15'h4000;
  localparam addr_t SCR_TOP  = 15'h5FFF;
  localparam addr_t KBD_ADDR = 15'h6000;

  typedef enum logic [1:0] {
    REG_RAM = 2'd0,
    REG_SCR = 2'd1,
    REG_KBD = 2'd2,
    REG_BAD = 2'd3
  } region_t;

  // Offset-based window test; unsigned wrap makes addresses below base fall outside.
  function automatic logic in_window(addr_t a, addr_t base, int unsigned words);
    addr_t off;
    off = a - base;
    return ({17'd0, off} < words);
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Synchronous read-first RAM: port A reads/writes, port B is read-only.
// Read registers reset to zero; the array itself is never cleared.
module dp_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_a,
  input  logic             re_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] wdata_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    addr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_a_reg;
  logic [WIDTH-1:0] rdata_b_reg;

  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[addr_a] <= wdata_a;
    end
  end

  // Both reads sample the array before this edge's write lands (read-first).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_a_reg <= '0;
      rdata_b_reg <= '0;
    end else begin
      if (re_a) begin
        rdata_a_reg <= mem[addr_a];
      end
      rdata_b_reg <= mem[addr_b];
    end
  end

  assign rdata_a = rdata_a_reg;
  assign rdata_b = rdata_b_reg;

endmodule

// File: rtl/hack_data_mem.sv
// Hack CPU data memory responder: RAM, screen buffer and keyboard register,
// with the two-cycle stalled read and a read-only scanner port on the screen.
module hack_data_mem #(
  parameter int          RAM_WORDS = 16384,
  parameter int          SCR_WORDS = 8192,
  parameter logic [14:0] KBD_ADDR  = hack_mem_pkg::KBD_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  input  logic        memread,
  output logic [15:0] inM,
  output logic        rd_valid,
  input  logic [12:0] scr_addr,
  output logic [15:0] scr_rdata,
  input  logic        kbd_strobe,
  input  logic [15:0] kbd_code,
  output logic        bad_access
);

  import hack_mem_pkg::*;

  localparam int RA_W = $clog2(RAM_WORDS);
  localparam int SA_W = $clog2(SCR_WORDS);

  region_t cpu_region;
  region_t rd_region_reg;
  logic    ph_reg;
  logic    capture;
  word_t   kbd_reg;
  word_t   kbd_rd_reg;
  logic    bad_reg;
  word_t   ram_rdata;
  word_t   scr_cpu_rdata;
  word_t   ram_b_unused;

  always_comb begin
    cpu_region = REG_BAD;
    if (in_window(addressM, RAM_BASE, RAM_WORDS)) begin
      cpu_region = REG_RAM;
    end else if (in_window(addressM, SCR_BASE, SCR_WORDS)) begin
      cpu_region = REG_SCR;
    end else if (addressM == KBD_ADDR) begin
      cpu_region = REG_KBD;
    end
  end

  // Only the first stall cycle samples; the second holds so M=M+1 sees the old value.
  assign capture = memread & ~ph_reg;

  dp_ram #(.DEPTH(RAM_WORDS), .WIDTH(16)) u_ram (
    .clk     (clk),
    .rst     (reset),
    .we_a    (writeM & (cpu_region == REG_RAM)),
    .re_a    (capture & (cpu_region == REG_RAM)),
    .addr_a  (addressM[RA_W-1:0]),
    .wdata_a (outM),
    .rdata_a (ram_rdata),
    .addr_b  ('0),
    .rdata_b (ram_b_unused)
  );

  dp_ram #(.DEPTH(SCR_WORDS), .WIDTH(16)) u_scr (
    .clk     (clk),
    .rst     (reset),
    .we_a    (writeM & (cpu_region == REG_SCR)),
    .re_a    (capture & (cpu_region == REG_SCR)),
    .addr_a  (addressM[SA_W-1:0]),
    .wdata_a (outM),
    .rdata_a (scr_cpu_rdata),
    .addr_b  (scr_addr[SA_W-1:0]),
    .rdata_b (scr_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_reg        <= 1'b0;
      rd_region_reg <= REG_BAD;
      kbd_reg       <= '0;
      kbd_rd_reg    <= '0;
      bad_reg       <= 1'b0;
    end else begin
      ph_reg <= memread ? ~ph_reg : 1'b0;
      if (capture) begin
        rd_region_reg <= cpu_region;
        if (cpu_region == REG_KBD) begin
          kbd_rd_reg <= kbd_reg;
        end
      end
      // A fresh key code beats a same-cycle CPU clear.
      if (kbd_strobe) begin
        kbd_reg <= kbd_code;
      end else if (writeM && (cpu_region == REG_KBD)) begin
        kbd_reg <= '0;
      end
      if ((memread || writeM) && (cpu_region == REG_BAD)) begin
        bad_reg <= 1'b1;
      end
    end
  end

  // Region register resets to REG_BAD so inM reads zero out of reset.
  always_comb begin
    inM = '0;
    unique case (rd_region_reg)
      REG_RAM: inM = ram_rdata;
      REG_SCR: inM = scr_cpu_rdata;
      REG_KBD: inM = kbd_rd_reg;
      REG_BAD: inM = '0;
    endcase
  end

  assign rd_valid   = memread & ph_reg;
  assign bad_access = bad_reg;

endmodule

// File: doc/hack_data_mem.md
Name: hack_data_mem

Overview:
- Data-side memory responder for the Hack CPU. Services addressM/outM/writeM and the CPU's two-cycle read stall (memread), and returns inM.
- Implements the Hack memory map:
  - RAM at 0x0000-0x3FFF
  - screen buffer at 0x4000-0x5FFF
  - keyboard register at 0x6000
- Provides a second, read-only screen port for the display scanner.
- Sits between the CPU and the display/keyboard front-ends.

Parameters:
- RAM_WORDS, 16384, general RAM depth (words, 16-bit each).
- SCR_WORDS, 8192, screen buffer depth.
- KBD_ADDR, 15'h6000, keyboard register address.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- addressM  input  15  CPU data address. Held stable across both cycles of a stalled read.
- outM  input  16  CPU write data.
- writeM  input  1  CPU write strobe, one cycle per write.
- memread  input  1  CPU stall/read request. High for exactly two consecutive cycles per M-reading instruction.
- inM  output  16  read data to the CPU.
- rd_valid  output  1  high in the cycle inM is valid (second stall cycle).
- scr_addr  input  13  display scanner word address.
- scr_rdata  output  16  screen word, one-cycle latency.
- kbd_strobe  input  1  one-cycle pulse: new key code present.
- kbd_code  input  16  key code, sampled when kbd_strobe=1.
- bad_access  output  1  sticky flag: access above KBD_ADDR.

Behaviour:

Reset:
- ph=0, inM=0, rd_valid=0, scr_rdata=0, kbd register=0, bad_access=0.
- RAM and screen contents are not cleared.

Phase register ph mirrors the CPU's stall phase:
- next ph = memread ? ~ph : 0.
- Back-to-back M-reading instructions (memread high for 4+ cycles) alternate 0,1,0,1.

Read:
- On a cycle with memread=1 and ph=0, decode addressM and perform a synchronous read into the read-data register; inM updates at that edge.
- On ph=1, the read-data register holds. rd_valid = memread & ph.
- Latency: inM is valid in the second stall cycle, exactly one edge after capture.
- Read data is never re-sampled in ph=1, so a read-modify-write instruction (M=M+1) sees the pre-write value even though writeM is high in that cycle.

Write:
- Any cycle with writeM=1 writes outM to the decoded target at the edge.
- No dependency on memread: a single-cycle write and a write in the second stall cycle are both legal.

Address decode:
- 0x0000-0x3FFF: RAM.
- 0x4000-0x5FFF: screen (index addressM[12:0]).
- 0x6000: keyboard.
  - A read returns the latched code.
  - A write clears the register to 0, regardless of outM.
- 0x6001-0x7FFF:
  - Reads return 0.
  - Writes are dropped.
  - Either access sets bad_access. It stays set until reset.

Keyboard:
- kbd_strobe=1 loads kbd_code.
- If a CPU write to KBD_ADDR occurs in the same cycle, the strobe wins (new code loaded).

Screen port:
- scr_rdata = screen[scr_addr] registered, one-cycle latency, independent of CPU traffic.
- Same-address CPU write and scanner read in the same cycle: scanner gets the old data (read-first).

Write-then-read:
- A write at edge N followed by a read captured at edge N+1 to the same address returns the new data.
- Same-edge write and read capture is impossible by protocol (ph=0 never coincides with a stall write). If it occurs anyway, the read returns the old data (read-first).

Reset mid-read:
- Forces ph=0 and rd_valid=0.
- The next memread is treated as a fresh first cycle.

Decomposition:
- Shared package hack_mem_pkg:
  - address-map constants: RAM_BASE, RAM_TOP, SCR_BASE, SCR_TOP, KBD_ADDR
  - region enum: {REG_RAM, REG_SCR, REG_KBD, REG_BAD}
  - 15-bit address and 16-bit word typedefs
- One sub-module, dp_ram: synchronous read-first RAM with parameter DEPTH, one write/read port and one read-only port.
  - Instance 1: RAM, second port unused.
  - Instance 2: screen, second port driven by scr_addr.
- Decode, phase, keyboard and error logic stay in hack_data_mem.

Test Plan:
1. Write RAM[0x0010]=0x1234 (writeM one cycle, memread=0), then memread 2 cycles at 0x0010 -> rd_valid high only in cycle 2, inM=0x1234.
2. M=M+1 pattern at 0x0020 (preloaded 0x00FF): memread 2 cycles, writeM in cycle 2 with outM=0x0100 -> inM=0x00FF through both cycles; subsequent read returns 0x0100.
3. CPU writes screen 0x4005=0xAAAA; scanner scr_addr=5 next cycle -> scr_rdata=0xAAAA one cycle later. Same-cycle write/scan of the same address -> old value.
4. kbd_strobe with code 0x0041, read 0x6000 -> inM=0x0041. Write 0x6000 -> reads 0. Strobe 0x0042 plus write in the same cycle -> reads 0x0042.
5. Read 0x6001 -> inM=0, bad_access=1 and stays set. Write 0x7FFF -> no RAM/screen change.
6. Four-cycle memread (two consecutive reads, 0x0001 then 0x0002, holding 0x1111/0x2222) with reset asserted in cycle 2 -> rd_valid=0, inM=0. After release, a fresh read of 0x0002 returns 0x2222 in its second cycle.
